// File: rtl/execution_controller.sv
// Execution controller: starts a CPU program run on request, counts the
// enabled cycles until HALT, snapshots PC and accumulator, and then streams a
// 6-byte report (cycle count, PC, ACC; each 16 bits, MSB first) to the UART.
module execution_controller #(
    parameter int NB_DATA   = 16,
    parameter int NB_PC     = 11,
    parameter int NB_CYCLES = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_program_done,
    input  logic [NB_PC-1:0]     i_pc,
    input  logic [NB_DATA-1:0]   i_acc,
    input  logic                 i_tx_done,
    output logic                 o_cpu_reset,
    output logic                 o_cpu_enb,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_report_done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [NB_CYCLES-1:0] CYCLES_MAX = '1;
    localparam logic [2:0]           LAST_IDX   = 3'd5;

    state_t               state_q, state_d;
    logic [NB_CYCLES-1:0] cycles_q, cycles_d;
    logic [2:0]           idx_q, idx_d;
    logic [15:0]          pc_snap_q, pc_snap_d;
    logic [NB_DATA-1:0]   acc_snap_q, acc_snap_d;

    logic                 cpu_reset_c;
    logic                 tx_start_c;
    logic                 report_done_c;
    logic [7:0]           report_byte;

    // Report fields are 16 bits: narrower sources are zero-extended, wider
    // sources keep only their low 16 bits.
    function automatic logic [15:0] fit_cycles(input logic [NB_CYCLES-1:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < NB_CYCLES) r[i] = v[i];
        end
        return r;
    endfunction

    function automatic logic [15:0] fit_pc(input logic [NB_PC-1:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < NB_PC) r[i] = v[i];
        end
        return r;
    endfunction

    function automatic logic [15:0] fit_acc(input logic [NB_DATA-1:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < NB_DATA) r[i] = v[i];
        end
        return r;
    endfunction

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cycles_q   <= '0;
            idx_q      <= '0;
            pc_snap_q  <= '0;
            acc_snap_q <= '0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            idx_q      <= idx_d;
            pc_snap_q  <= pc_snap_d;
            acc_snap_q <= acc_snap_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d       = state_q;
        cycles_d      = cycles_q;
        idx_d         = idx_q;
        pc_snap_d     = pc_snap_q;
        acc_snap_d    = acc_snap_q;
        cpu_reset_c   = 1'b0;
        tx_start_c    = 1'b0;
        report_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = CLEAR;
            end
            CLEAR: begin
                cpu_reset_c = 1'b1;
                cycles_d    = '0;
                idx_d       = '0;
                state_d     = RUN;
            end
            RUN: begin
                // The HALT cycle itself is not counted.
                if (i_program_done) begin
                    pc_snap_d  = fit_pc(i_pc);
                    acc_snap_d = i_acc;
                    state_d    = SEND;
                end else if (cycles_q != CYCLES_MAX) begin
                    cycles_d = cycles_q + 1'b1;
                end
            end
            SEND: begin
                tx_start_c = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        report_done_c = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Report byte selected by the current index, MSB of each field first.
    always_comb begin
        report_byte = 8'h00;
        case (idx_q)
            3'd0:    report_byte = fit_cycles(cycles_q)[15:8];
            3'd1:    report_byte = fit_cycles(cycles_q)[7:0];
            3'd2:    report_byte = pc_snap_q[15:8];
            3'd3:    report_byte = pc_snap_q[7:0];
            3'd4:    report_byte = fit_acc(acc_snap_q)[15:8];
            3'd5:    report_byte = fit_acc(acc_snap_q)[7:0];
            default: report_byte = 8'h00;
        endcase
    end

    // Outputs are forced low while reset is asserted; the byte stays on
    // o_tx_data from SEND until the transmitter reports completion.
    always_comb begin
        o_cpu_reset   = cpu_reset_c & ~i_reset;
        o_cpu_enb     = (state_q == RUN) & ~i_program_done & ~i_reset;
        o_tx_start    = tx_start_c & ~i_reset;
        o_busy        = (state_q != IDLE) & ~i_reset;
        o_report_done = report_done_c & ~i_reset;
        o_tx_data     = 8'h00;
        if (!i_reset && (state_q == SEND || state_q == WAIT_TX)) begin
            o_tx_data = report_byte;
        end
    end

endmodule

// File: tb/tb_execution_controller.sv
// Bench for execution_controller: a default instance (16-bit counter) and a
// 4-bit-counter instance share all stimulus; each report is compared against
// bytes computed from the run length, PC and ACC.
module tb_execution_controller;

    localparam int NB_DATA = 16;
    localparam int NB_PC   = 11;

    logic               clk = 1'b0;
    logic               rst, start, pdone, txd;
    logic [NB_PC-1:0]   pc;
    logic [NB_DATA-1:0] acc;

    logic       cpu_reset_a, enb_a, txstart_a, busy_a, rdone_a;
    logic [7:0] txdata_a;
    logic       cpu_reset_b, enb_b, txstart_b, busy_b, rdone_b;
    logic [7:0] txdata_b;

    int total = 0;
    int bad   = 0;
    int txs_a = 0;
    int rdone_cnt = 0;
    int enb_cnt = 0;

    always #5 clk = ~clk;

    execution_controller #(.NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_CYCLES(16)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_program_done(pdone),
        .i_pc(pc), .i_acc(acc), .i_tx_done(txd),
        .o_cpu_reset(cpu_reset_a), .o_cpu_enb(enb_a), .o_tx_data(txdata_a),
        .o_tx_start(txstart_a), .o_busy(busy_a), .o_report_done(rdone_a)
    );

    execution_controller #(.NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_CYCLES(4)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_program_done(pdone),
        .i_pc(pc), .i_acc(acc), .i_tx_done(txd),
        .o_cpu_reset(cpu_reset_b), .o_cpu_enb(enb_b), .o_tx_data(txdata_b),
        .o_tx_start(txstart_b), .o_busy(busy_b), .o_report_done(rdone_b)
    );

    always @(negedge clk) begin
        if (txstart_a) txs_a <= txs_a + 1;
        if (rdone_a)   rdone_cnt <= rdone_cnt + 1;
        if (enb_a)     enb_cnt <= enb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference report: count saturates at 2^w-1, fields are 16 bits, MSB first.
    function automatic logic [7:0] exp_byte(input int n, input int w, input logic [15:0] pcv,
                                            input logic [15:0] accv, input int i);
        int          cnt;
        logic [15:0] f;
        cnt = (n > (1 << w) - 1) ? (1 << w) - 1 : n;
        case (i / 2)
            0:       f = 16'(cnt);
            1:       f = pcv;
            default: f = accv;
        endcase
        return (i % 2 == 0) ? f[15:8] : f[7:0];
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset_a, 0);
        chk({tag, "_enb"},       enb_a,       0);
        chk({tag, "_data"},      txdata_a,    0);
        chk({tag, "_start"},     txstart_a,   0);
        chk({tag, "_busy"},      busy_a,      0);
        chk({tag, "_rdone"},     rdone_a,     0);
        chk({tag, "_busy_b"},    busy_b,      0);
    endtask

    // One program run of n enabled cycles followed by HALT, then the report.
    // delay: idle cycles before each i_tx_done; noise: stray i_start/i_tx_done;
    // abort_idx: byte index during whose wait reset is applied (-1 = none).
    task automatic do_run(input int n, input logic [NB_PC-1:0] pcv, input logic [NB_DATA-1:0] accv,
                          input int delay, input bit noise, input int abort_idx);
        int          base_tx, base_rd, base_enb, t;
        logic [15:0] pc16;
        logic [7:0]  ea, eb;
        pc16     = 16'(pcv);
        base_tx  = txs_a;
        base_rd  = rdone_cnt;
        base_enb = enb_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("clear_cpu_reset", cpu_reset_a, 1);
        chk("clear_busy", busy_a, 1);
        chk("clear_enb", enb_a, 0);
        chk("clear_cpu_reset_b", cpu_reset_b, 1);
        @(posedge clk); #1;
        pc = pcv; acc = accv; pdone = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (noise && k == 1) begin start = 1'b1; txd = 1'b1; end
            @(negedge clk);
            chk("run_enb", enb_a, 1);
            chk("run_enb_b", enb_b, 1);
            chk("run_cpu_reset", cpu_reset_a, 0);
            chk("run_tx_start", txstart_a, 0);
            @(posedge clk); #1 start = 1'b0; txd = 1'b0;
        end
        pdone = 1'b1;
        @(negedge clk);
        chk("halt_enb", enb_a, 0);
        chk("halt_busy", busy_a, 1);
        @(posedge clk); #1 pdone = 1'b0;
        pc = NB_PC'($urandom); acc = NB_DATA'($urandom);
        for (int i = 0; i < 6; i++) begin
            t = 0;
            @(negedge clk);
            while (!txstart_a && t < 4) begin @(negedge clk); t++; end
            chk("tx_start_seen", txstart_a, 1);
            if (!txstart_a) return;
            ea = exp_byte(n, 16, pc16, 16'(accv), i);
            eb = exp_byte(n, 4, pc16, 16'(accv), i);
            chk($sformatf("byte%0d", i), txdata_a, ea);
            chk($sformatf("byte%0d_sat", i), txdata_b, eb);
            @(posedge clk); #1;
            for (int d = 0; d < delay; d++) begin
                if (noise && d == 0) start = 1'b1;
                @(negedge clk);
                chk("hold_data", txdata_a, ea);
                chk("hold_start", txstart_a, 0);
                chk("hold_busy", busy_a, 1);
                @(posedge clk); #1 start = 1'b0;
            end
            if (abort_idx == i) begin
                rst = 1'b1;
                @(negedge clk);
                all_zero("in_rst");
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                all_zero("after_rst");
                repeat (10) @(posedge clk);
                #1;
                chk("abort_tx_count", txs_a - base_tx, i + 1);
                chk("abort_rdone", rdone_cnt - base_rd, 0);
                return;
            end
            txd = 1'b1;
            @(negedge clk);
            chk("rdone_pulse", rdone_a, (i == 5) ? 1 : 0);
            chk("done_data", txdata_a, ea);
            @(posedge clk); #1 txd = 1'b0;
        end
        @(negedge clk);
        chk("end_busy", busy_a, 0);
        chk("end_data", txdata_a, 0);
        chk("end_rdone", rdone_a, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("tx_count", txs_a - base_tx, 6);
        chk("rdone_count", rdone_cnt - base_rd, 1);
        chk("enb_count", enb_cnt - base_enb, n);
    endtask

    initial begin
        int n, dl;
        bit nz;
        rst = 1'b1; start = 1'b0; pdone = 1'b0; txd = 1'b0; pc = '0; acc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        all_zero("post_reset");
        txd = 1'b1;
        @(posedge clk); #1 txd = 1'b0;
        @(negedge clk);
        chk("idle_tx_done_ignored", busy_a, 0);

        do_run(7, 11'd7, 16'h0012, 0, 1'b0, -1);
        do_run(0, 11'h5A3, 16'hBEEF, 1, 1'b0, -1);
        do_run(20, 11'h123, 16'h4567, 0, 1'b0, -1);
        do_run(15, 11'h7FF, 16'hFFFF, 0, 1'b0, -1);
        do_run(16, 11'h001, 16'h0000, 0, 1'b0, -1);
        do_run(5, 11'h2AA, 16'h8001, 2, 1'b1, -1);
        do_run(3, 11'h0F0, 16'hA5C3, 100, 1'b0, -1);
        do_run(9, 11'h155, 16'h1234, 1, 1'b0, 2);
        do_run(4, 11'h321, 16'h0ABC, 0, 1'b0, -1);

        // A program that never halts stays in RUN until reset.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("nohalt_busy", busy_a, 1);
        chk("nohalt_enb", enb_a, 1);
        chk("nohalt_tx", txstart_a, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        all_zero("nohalt_rst");

        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(0, 40);
            nz = 1'($urandom_range(0, 1));
            dl = $urandom_range(0, 4);
            if (nz && dl == 0) dl = 1;
            if (nz && n < 2) n = 2;
            do_run(n, NB_PC'($urandom), NB_DATA'($urandom), dl, nz, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
